regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_sb_board.sv | 52 +++++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, reset-value encoding, address width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // INIT_INDEX encodings: all-zero reset, or register i resets to value i.
  localparam int INIT_ZERO = 0;
  localparam int INIT_IDX  = 1;

  // Address width for a register count (ceil(log2(n))).
  function automatic int aw_of(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_sb_board.sv
// Scoreboard for the register file: pending bit per register, registered pending count, stray-writeback flag.
// Latency: pending/pend_cnt/wb_err update one edge after set/clear requests.
// Backpressure: none here; the parent gates set_en with its issue-ready decision.
// Ports: clk, reset (async active-low); set_en/set_idx reserve a register; clr_en/clr_idx release one;
//        pending is the live bit vector, pend_cnt its population count, wb_err a one-cycle pulse.
module regfile_sb_board
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = aw_of(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_cnt,
  output logic            wb_err
);

  logic [NREG-1:0] pend_d;
  logic [AW:0]     cnt_d;

  // Clear is applied before set so a writeback and a new reservation of the
  // same register in one cycle leave that register pending.
  always_comb begin
    pend_d = pending;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
    // Count is derived from the next bit vector, so it can never drift or wrap.
    cnt_d = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      pend_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      pending  <= pend_d;
      pend_cnt <= cnt_d;
      wb_err   <= clr_en && !pending[clr_idx];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and per-register pending scoreboard.
// Latency: reads combinational (same-cycle bypass of writeback); writes and reservations land at the next edge.
// Backpressure: iss_ready drops while the destination has a write outstanding, unless it is released this cycle.
// Ports: ra/rd/rd_busy are NRD packed read lanes; iss_valid/iss_rd/iss_ready reserve a destination;
//        we/wa/wd write back and release; wb_err flags a writeback to a non-pending register; pend_cnt counts pending.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NREG       = NREG_DEF,
  parameter int NRD        = 2,
  parameter int INIT_INDEX = INIT_ZERO,
  localparam int AW        = aw_of(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  output logic              wb_err,
  output logic [AW:0]       pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic            wr_en;
  logic            set_en;
  logic [AW-1:0]   ra_p;
  logic            hit;

  // x0 is never written and never reserved.
  assign wr_en  = we && (wa != '0);
  assign set_en = iss_valid && iss_ready && (iss_rd != '0);

  // A writeback to the requested destination in the same cycle frees it.
  assign iss_ready = reset &&
                     ((iss_rd == '0) || !pending[iss_rd] || (we && (wa == iss_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (INIT_INDEX == INIT_IDX) ? XLEN'(i) : '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Read lanes: zero during reset and for x0, otherwise bypass a matching writeback.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    ra_p    = '0;
    hit     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra_p = ra[p*AW +: AW];
      hit  = we && (wa == ra_p);
      if (reset && (ra_p != '0)) begin
        rd[p*XLEN +: XLEN] = hit ? wd : regs[ra_p];
        rd_busy[p]         = pending[ra_p] && !hit;
      end
    end
  end

  regfile_sb_board #(
    .NREG (NREG)
  ) u_board (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (iss_rd),
    .clr_en   (wr_en),
    .clr_idx  (wa),
    .pending  (pending),
    .pend_cnt (pend_cnt),
    .wb_err   (wb_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*XLEN-1:0]  rd;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_ready;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [XLEN-1:0]      wd;
  logic                 wb_err;
  logic [AW:0]          pend_cnt;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN       (XLEN),
    .NREG       (NREG),
    .NRD        (NRD),
    .INIT_INDEX (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .wb_err    (wb_err),
    .pend_cnt  (pend_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Expected registered outputs after the upcoming edge; popped one cycle later.
  typedef struct {
    string       tag;
    logic [AW:0] cnt;
    logic        err;
  } reg_exp_t;
  reg_exp_t sb_q[$];

  typedef struct {
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          iv;
    logic [AW-1:0] ird;
    logic [31:0]   e0;
    logic [31:0]   e1;
    logic [1:0]    eb;
    logic          er;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_reg(input string tag, input int cnt, input bit err);
    reg_exp_t e;
    e.tag = tag;
    e.cnt = (AW+1)'(cnt);
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    reg_exp_t e;
    @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, " pend_cnt"}, 32'(pend_cnt), 32'(e.cnt));
      chk({e.tag, " wb_err"},   32'(wb_err),   32'(e.err));
    end
  endtask

  task automatic drive(input int r0, input int r1, input bit v, input int ird,
                       input bit w, input int a, input logic [31:0] d);
    ra        = {AW'(r1), AW'(r0)};
    iss_valid = v;
    iss_rd    = AW'(ird);
    we        = w;
    wa        = AW'(a);
    wd        = d;
  endtask

  function automatic logic [31:0] lane(input int p);
    return rd[p*XLEN +: XLEN];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{5'd5,  5'd31, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd5,        32'd31,       2'b00, 1'b1};
    vt[1] = '{5'd0,  5'd1,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,        32'd1,        2'b00, 1'b1};
    vt[2] = '{5'd4,  5'd4,  1'b1, 5'd4, 32'hAAAA5555, 1'b0, 5'd0, 32'hAAAA5555, 32'hAAAA5555, 2'b00, 1'b1};
    vt[3] = '{5'd0,  5'd3,  1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'd0,        32'd3,        2'b00, 1'b1};
    vt[4] = '{5'd30, 5'd2,  1'b1, 5'd2, 32'h77,       1'b0, 5'd0, 32'd30,       32'h77,       2'b00, 1'b1};
    vt[5] = '{5'd6,  5'd9,  1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'd6,        32'd9,        2'b00, 1'b1};

    // Reset held: outputs forced low, writes and issues ignored.
    reset = 1'b0;
    drive(5, 31, 1'b1, 3, 1'b1, 5, 32'hFFFF_FFFF);
    #3;
    chk("rst rd0", lane(0), 32'd0);
    chk("rst rd1", lane(1), 32'd0);
    chk("rst busy", 32'(rd_busy), 32'd0);
    chk("rst ready", 32'(iss_ready), 32'd0);
    chk("rst pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst wb_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst hold pend_cnt", 32'(pend_cnt), 32'd0);
    drive(0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
    #1 reset = 1'b1;
    push_reg("release", 0, 1'b0);

    // Combinational vectors: strobes dropped before the edge, so no state changes.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(vt[i].ra0, vt[i].ra1, vt[i].iv, vt[i].ird, vt[i].w, vt[i].a, vt[i].d);
      #2;
      chk($sformatf("vec%0d rd0", i), lane(0), vt[i].e0);
      chk($sformatf("vec%0d rd1", i), lane(1), vt[i].e1);
      chk($sformatf("vec%0d busy", i), 32'(rd_busy), 32'(vt[i].eb));
      chk($sformatf("vec%0d ready", i), 32'(iss_ready), 32'(vt[i].er));
      #1 drive(0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
      push_reg("vec", 0, 1'b0);
    end

    // Reserve x7, observe busy and blocked re-issue, then write it back.
    tick(); drive(7, 0, 1'b1, 7, 1'b0, 0, 32'h0); #2;
    chk("iss7 ready", 32'(iss_ready), 32'd1);
    push_reg("iss7", 1, 1'b0);
    tick(); drive(7, 0, 1'b1, 7, 1'b0, 0, 32'h0); #2;
    chk("x7 busy", 32'(rd_busy), 32'b01);
    chk("x7 reissue ready", 32'(iss_ready), 32'd0);
    push_reg("iss7 blocked", 1, 1'b0);
    tick(); drive(7, 0, 1'b0, 0, 1'b1, 7, 32'hDEADBEEF); #2;
    chk("wb7 bypass", lane(0), 32'hDEADBEEF);
    chk("wb7 busy", 32'(rd_busy), 32'd0);
    push_reg("wb7", 0, 1'b0);
    tick(); drive(7, 0, 1'b0, 0, 1'b0, 0, 32'h0); #2;
    chk("x7 stored", lane(0), 32'hDEADBEEF);
    push_reg("idle7", 0, 1'b0);

    // x9 pending; same-cycle writeback and re-issue keeps it pending.
    tick(); drive(9, 0, 1'b1, 9, 1'b0, 0, 32'h0); #2;
    chk("iss9 ready", 32'(iss_ready), 32'd1);
    push_reg("iss9", 1, 1'b0);
    tick(); drive(9, 0, 1'b1, 9, 1'b1, 9, 32'h99); #2;
    chk("iss+wb9 ready", 32'(iss_ready), 32'd1);
    chk("iss+wb9 bypass", lane(0), 32'h99);
    push_reg("iss+wb9", 1, 1'b0);
    tick(); drive(9, 0, 1'b0, 0, 1'b0, 0, 32'h0); #2;
    chk("x9 stored", lane(0), 32'h99);
    chk("x9 still busy", 32'(rd_busy), 32'b01);
    push_reg("idle9", 1, 1'b0);
    tick(); drive(9, 0, 1'b0, 0, 1'b1, 9, 32'h100); #2;
    chk("wb9b bypass", lane(0), 32'h100);
    push_reg("wb9b", 0, 1'b0);

    // x0 writes and issues are ignored.
    tick(); drive(0, 0, 1'b1, 0, 1'b1, 0, 32'h1234); #2;
    chk("x0 rd0", lane(0), 32'd0);
    chk("x0 ready", 32'(iss_ready), 32'd1);
    chk("x0 busy", 32'(rd_busy), 32'd0);
    push_reg("x0", 0, 1'b0);
    tick(); drive(0, 0, 1'b0, 0, 1'b0, 0, 32'h0); #2;
    chk("x0 after", lane(0), 32'd0);
    push_reg("idle0", 0, 1'b0);

    // Stray writeback to non-pending x3: data lands, wb_err pulses once.
    tick(); drive(0, 3, 1'b0, 0, 1'b1, 3, 32'h55); #2;
    chk("wb3 bypass", lane(1), 32'h55);
    push_reg("wb3 stray", 0, 1'b1);
    tick(); drive(0, 3, 1'b0, 0, 1'b0, 0, 32'h0); #2;
    chk("x3 stored", lane(1), 32'h55);
    push_reg("after stray", 0, 1'b0);
    tick(); drive(0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
    push_reg("idle3", 0, 1'b0);

    // Fill every register, then try one more: count saturates naturally at 31.
    for (int i = 1; i < 32; i++) begin
      tick(); drive(0, 0, 1'b1, i, 1'b0, 0, 32'h0); #2;
      chk($sformatf("fill x%0d ready", i), 32'(iss_ready), 32'd1);
      push_reg("fill", i, 1'b0);
    end
    tick(); drive(31, 1, 1'b1, 31, 1'b0, 0, 32'h0); #2;
    chk("full ready", 32'(iss_ready), 32'd0);
    chk("full busy", 32'(rd_busy), 32'b11);
    push_reg("full", 31, 1'b0);

    // Reset mid-stream with issue still asserted.
    tick(); drive(5, 7, 1'b1, 31, 1'b0, 0, 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("midrst pend_cnt", 32'(pend_cnt), 32'd0);
    chk("midrst busy", 32'(rd_busy), 32'd0);
    chk("midrst rd0", lane(0), 32'd0);
    chk("midrst ready", 32'(iss_ready), 32'd0);
    @(negedge clk);
    #1 drive(5, 7, 1'b1, 5, 1'b0, 0, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("fresh rd0", lane(0), 32'd5);
    chk("fresh rd1", lane(1), 32'd7);
    chk("fresh busy", 32'(rd_busy), 32'd0);
    chk("fresh ready", 32'(iss_ready), 32'd1);
    push_reg("fresh iss5", 1, 1'b0);
    tick(); drive(5, 7, 1'b0, 0, 1'b0, 0, 32'h0); #2;
    chk("fresh x5 busy", 32'(rd_busy), 32'b01);
    push_reg("fresh idle", 1, 1'b0);
    tick();
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
